// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2 -- four-channel 2x2 non-overlapping max-pool with optional ReLU.
//
// Consumes four raster-ordered signed pixel streams sharing one (row, col)
// position and emits one pooled pixel per channel per 2x2 window, one cycle
// after the pixel that completes the window.
//
// Optional feature: define RELU_EN to clamp negative pooled results to zero.
//
// Ports (top):
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active low
//   in_valid                 in_pixel1..4 carry the current raster position
//   in_pixel1..in_pixel4     signed DATA_W pixels, channels 1..4
//   flush                    synchronous frame restart, beats in_valid
//   out_valid                out_pixel1..4 updated this cycle (1-cycle pulse)
//   out_pixel1..out_pixel4   signed DATA_W pooled pixels, held between pulses
//   frame_done               pulse alongside the last pooled output of a frame

// Per-channel datapath: horizontal pair register, half-width line buffer and
// the registered pooled output.
module relu_maxpool2x2_lane #(
    parameter int DATA_W = 36,
    parameter int NENT   = 4,
    parameter int IDX_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en_i,
    input  logic                     col_odd_i,
    input  logic                     row_odd_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic signed [DATA_W-1:0] pix_i,
    output logic signed [DATA_W-1:0] out_o
);
    logic signed [DATA_W-1:0] hreg_q;
    logic signed [DATA_W-1:0] out_q;
    logic signed [DATA_W-1:0] lb_q [NENT];
    logic signed [DATA_W-1:0] hmax, lb_rd, pooled, res;

    always_comb begin
        hmax   = (hreg_q > pix_i) ? hreg_q : pix_i;
        lb_rd  = lb_q[idx_i];
        pooled = (lb_rd > hmax) ? lb_rd : hmax;
`ifdef RELU_EN
        res    = pooled[DATA_W-1] ? '0 : pooled;
`else
        res    = pooled;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hreg_q <= '0;
            out_q  <= '0;
        end else if (pix_en_i) begin
            if (!col_odd_i)
                hreg_q <= pix_i;
            else if (row_odd_i)
                out_q <= res;
        end
    end

    // Line buffer is deliberately unreset: every odd-row read is preceded by
    // an even-row write of the same entry within the current frame.
    always_ff @(posedge clk) begin
        if (pix_en_i && col_odd_i && !row_odd_i)
            lb_q[idx_i] <= hmax;
    end

    assign out_o = out_q;
endmodule

module relu_maxpool2x2 #(
    parameter int DATA_W = 36,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_pixel1,
    input  logic signed [DATA_W-1:0] in_pixel2,
    input  logic signed [DATA_W-1:0] in_pixel3,
    input  logic signed [DATA_W-1:0] in_pixel4,
    input  logic                     flush,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_pixel1,
    output logic signed [DATA_W-1:0] out_pixel2,
    output logic signed [DATA_W-1:0] out_pixel3,
    output logic signed [DATA_W-1:0] out_pixel4,
    output logic                     frame_done
);
    localparam int NUM_LANES = 4;
    localparam int NENT      = IMG_W / 2;
    localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W     = (NENT > 1) ? $clog2(NENT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d, col_half;
    logic [ROW_W-1:0] row_q, row_d;
    logic             out_valid_q, frame_done_q;
    logic             pix_en, win_done, frame_last;
    logic [IDX_W-1:0] idx;

    logic [NUM_LANES-1:0][DATA_W-1:0] pix_in;
    logic [NUM_LANES-1:0][DATA_W-1:0] pix_out;

    assign pix_in = {in_pixel4, in_pixel3, in_pixel2, in_pixel1};

    // flush wins over in_valid: the coincident pixel is dropped entirely.
    assign pix_en     = in_valid && !flush;
    assign win_done   = pix_en && col_q[0] && row_q[0];
    assign frame_last = win_done && (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign col_half   = col_q >> 1;
    assign idx        = IDX_W'(col_half);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (flush) begin
            col_d = '0;
            row_d = '0;
        end else if (in_valid) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= win_done;
            frame_done_q <= frame_last;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        relu_maxpool2x2_lane #(
            .DATA_W (DATA_W),
            .NENT   (NENT),
            .IDX_W  (IDX_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .pix_en_i  (pix_en),
            .col_odd_i (col_q[0]),
            .row_odd_i (row_q[0]),
            .idx_i     (idx),
            .pix_i     (pix_in[g]),
            .out_o     (pix_out[g])
        );
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_pixel1 = pix_out[0];
    assign out_pixel2 = pix_out[1];
    assign out_pixel3 = pix_out[2];
    assign out_pixel4 = pix_out[3];
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Testbench for relu_maxpool2x2 on a 4x4 frame. Each table record is one
// 2x2 window of channel 1 with its hand-computed max; four consecutive
// records form a frame in window raster order. Channel k carries the same
// pixels offset by 64*k so lanes are distinguishable.
module tb_relu_maxpool2x2;
    localparam int DW = 36;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic signed [DW-1:0] ip1 = '0, ip2 = '0, ip3 = '0, ip4 = '0;
    logic signed [DW-1:0] op1, op2, op3, op4;
    logic ov, fd;
    logic signed [DW-1:0] opx [4];

    always #5 clk = ~clk;

    relu_maxpool2x2 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pixel1  (ip1),
        .in_pixel2  (ip2),
        .in_pixel3  (ip3),
        .in_pixel4  (ip4),
        .flush      (flush),
        .out_valid  (ov),
        .out_pixel1 (op1),
        .out_pixel2 (op2),
        .out_pixel3 (op3),
        .out_pixel4 (op4),
        .frame_done (fd)
    );

    assign opx[0] = op1;
    assign opx[1] = op2;
    assign opx[2] = op3;
    assign opx[3] = op4;

    typedef struct {
        logic signed [DW-1:0] px [4];  // (r0,c0) (r0,c1) (r1,c0) (r1,c1)
        logic signed [DW-1:0] mx;      // max of the window, before ReLU
    } win_t;

    win_t tbl [16];
    int n_chk = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic signed [DW-1:0] last_exp [4];

    function automatic logic signed [DW-1:0] chan(input int k, input logic signed [DW-1:0] v);
        logic signed [DW-1:0] off;
        off = DW'(64 * k);
        return v + off;
    endfunction

    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v);
`ifdef RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic signed [DW-1:0] got,
                       input logic signed [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive (r,c) of frame f, then check what the edge produced.
    task automatic tick(input logic v, input logic fl, input int f, input int r, input int c);
        int wi, ei;
        logic wc;
        logic signed [DW-1:0] e;
        wi = 4 * f + (r / 2) * 2 + (c / 2);
        ei = (r % 2) * 2 + (c % 2);
        in_valid = v;
        flush    = fl;
        ip1 = chan(0, tbl[wi].px[ei]);
        ip2 = chan(1, tbl[wi].px[ei]);
        ip3 = chan(2, tbl[wi].px[ei]);
        ip4 = chan(3, tbl[wi].px[ei]);
        @(posedge clk);
        #1;
        wc = v && !fl && (r % 2 == 1) && (c % 2 == 1);
        chk("out_valid", DW'(ov), DW'(wc));
        if (wc) begin
            for (int k = 0; k < 4; k++) begin
                e = act(chan(k, tbl[wi].mx));
                chk($sformatf("pool_f%0d_r%0d_c%0d_ch%0d", f, r, c, k + 1), opx[k], e);
                last_exp[k] = e;
            end
            chk("frame_done", DW'(fd), DW'(r == H - 1 && c == W - 1));
        end else begin
            chk("hold_pix1", op1, last_exp[0]);
            chk("frame_done_idle", DW'(fd), '0);
        end
        if (fd) fd_cnt++;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Drive frame f in raster order up to (not including) (stop_r, stop_c).
    task automatic frame(input int f, input bit gap, input int stop_r = H, input int stop_c = 0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c >= stop_r * W + stop_c) return;
                if (gap && $urandom_range(0, 1) == 1) tick(1'b0, 1'b0, f, r, c);
                tick(1'b1, 1'b0, f, r, c);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ov"}, DW'(ov), '0);
        chk({tag, "_fd"}, DW'(fd), '0);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_pix%0d", tag, k + 1), opx[k], '0);
    endtask

    initial begin
        int fd0;
        // Frame 0: ramp r*4+c
        tbl[0]  = '{px: '{0, 1, 4, 5},        mx: 5};
        tbl[1]  = '{px: '{2, 3, 6, 7},        mx: 7};
        tbl[2]  = '{px: '{8, 9, 12, 13},      mx: 13};
        tbl[3]  = '{px: '{10, 11, 14, 15},    mx: 15};
        // Frame 1: negative, includes the most negative value
        tbl[4]  = '{px: '{-10, -3, -7, -4},   mx: -3};
        tbl[5]  = '{px: '{-3, -9, -8, -20},   mx: -3};
        tbl[6]  = '{px: '{-5, -6, -3, -100},  mx: -3};
        tbl[7]  = '{px: '{36'sh800000000, -1, -5, -7}, mx: -1};
        // Frame 2: mixed signs and ties
        tbl[8]  = '{px: '{100, -200, 50, -1}, mx: 100};
        tbl[9]  = '{px: '{-5, -5, -5, -5},    mx: -5};
        tbl[10] = '{px: '{-1, 0, 0, -1},      mx: 0};
        tbl[11] = '{px: '{7, 7, 300, -300},   mx: 300};
        // Frame 3: max in each window position
        tbl[12] = '{px: '{9, 1, 2, 3},        mx: 9};
        tbl[13] = '{px: '{1, 9, 2, 3},        mx: 9};
        tbl[14] = '{px: '{1, 2, 9, 3},        mx: 9};
        tbl[15] = '{px: '{1, 2, 3, 9},        mx: 9};
        for (int k = 0; k < 4; k++) last_exp[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int f = 0; f < 4; f++) frame(f, 1'b0);
        frame(0, 1'b1);
        frame(2, 1'b1);

        // Flush at (1,2): window at (1,1) already produced, (1,3) never does.
        frame(0, 1'b0, 1, 2);
        tick(1'b1, 1'b1, 0, 1, 2);
        tick(1'b0, 1'b0, 0, 1, 3);
        frame(3, 1'b0);

        // Reset low for two cycles at (3,1) of frame 2.
        frame(2, 1'b0, 3, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid0");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("rst_mid");
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) last_exp[k] = '0;
        frame(3, 1'b0);

        // Back-to-back frames.
        fd0 = fd_cnt;
        frame(1, 1'b0);
        frame(2, 1'b0);
        frame(0, 1'b0);
        tick(1'b0, 1'b0, 0, 0, 0);
        chk("frame_done_count", DW'(fd_cnt - fd0), DW'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
